// File: rtl/gray_a_binario_secuencial_if.sv
// Handshake bundle for the sequential Gray-to-binary decoder.
// Both sides use valid/ready: a transfer happens on the rising clock edge
// where valid and ready are both high. Valid, once raised, holds its data
// stable until that edge. Ready may be raised or lowered at any time.
interface gray_a_binario_secuencial_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] gray_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] binario_out;
  logic             ocupado;
  logic [1:0]       dbg_state;   // FSM state for checkers: 0 IDLE, 1 DECODE, 2 DONE

  // Decoder side
  modport slave (
    input  in_valid,
    input  gray_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output binario_out,
    output ocupado,
    output dbg_state
  );

  // Producer/consumer side
  modport master (
    output in_valid,
    output gray_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  binario_out,
    input  ocupado,
    input  dbg_state
  );
endinterface

// File: rtl/gray_a_binario_secuencial.sv
// Sequential Gray-to-binary decoder: accepts one Gray word, resolves one
// bit per clock from the MSB down (b[i] = b[i+1] ^ g[i]), then presents the
// binary word until the consumer takes it. One word in flight at a time.
module gray_a_binario_secuencial #(
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  gray_a_binario_secuencial_if.slave   bus
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_g;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_out;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_ocupado;

  logic [IDX_W-1:0] w_idx_up;
  logic             w_bit;
  logic [WIDTH-1:0] w_b_next;

  // Bit resolved this cycle; the MSB has no higher neighbour and passes through.
  always_comb begin
    w_idx_up         = r_idx + IDX_W'(1);
    w_bit            = (r_idx == IDX_TOP) ? r_g[r_idx] : (r_b[w_idx_up] ^ r_g[r_idx]);
    w_b_next         = r_b;
    w_b_next[r_idx]  = w_bit;
  end

  // Control FSM with registered handshake outputs and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_g         <= '0;
      r_b         <= '0;
      r_out       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_ocupado   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // in_ready is always high here, so in_valid alone completes the accept.
          if (bus.in_valid) begin
            r_g        <= bus.gray_in;
            r_idx      <= IDX_TOP;
            r_in_ready <= 1'b0;
            r_ocupado  <= 1'b1;
            r_state    <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          r_b <= w_b_next;
          if (r_idx == '0) begin
            // Last bit: publish the full word on the same edge that finishes it.
            r_out       <= w_b_next;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_idx <= r_idx - IDX_W'(1);
          end
        end
        ST_DONE: begin
          // r_out stays untouched here and after the handoff, until the next word completes.
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_ocupado   <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_ocupado   <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.binario_out = r_out;
  assign bus.ocupado     = r_ocupado;
  assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_gray_a_binario_secuencial.sv
// Directed bench for the sequential Gray-to-binary decoder. Expected words
// are queued when a word is accepted and compared when the result is taken.
module tb_gray_a_binario_secuencial;

  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 64;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gray_a_binario_secuencial_if #(.WIDTH(WIDTH)) bus ();

  gray_a_binario_secuencial #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [WIDTH-1:0] exp_q[$];
  int n_checks   = 0;
  int n_errors   = 0;
  int cyc        = 0;
  int accept_cyc = 0;
  int last_rise  = -1;
  bit exp_busy   = 1'b0;
  bit prev_ov    = 1'b0;
  bit bb_mode    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference binary-to-Gray encoder.
  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Monitor: sampled on the falling edge, i.e. what the next rising edge will see.
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready_vs_busy", {31'd0, bus.in_ready}, {31'd0, !exp_busy});
      check("ocupado", {31'd0, bus.ocupado}, {31'd0, exp_busy});
      if (bus.out_valid && !prev_ov) begin
        check("latency", cyc - accept_cyc, WIDTH);
        if (bb_mode && last_rise >= 0)
          check("throughput", cyc - last_rise, WIDTH + 2);
        last_rise = cyc;
      end
      if (bus.in_valid && bus.in_ready) begin
        accept_cyc = cyc + 1;
        exp_busy   = 1'b1;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0)
          check("unexpected_output", {24'd0, bus.binario_out}, 32'hFFFF_FFFF);
        else
          check("data", {24'd0, bus.binario_out}, {24'd0, exp_q.pop_front()});
        exp_busy = 1'b0;
      end
    end
    prev_ov = bus.out_valid;
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [WIDTH-1:0] g, input logic [WIDTH-1:0] exp);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.gray_in  = g;
    @(negedge clk);
    while (!bus.in_ready && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    if (n >= TIMEOUT) check("accept_timeout", n, 0);
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.gray_in  = WIDTH'($urandom_range(0, 255));  // must be ignored from here on
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 4 * TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4 * TIMEOUT) check("drain_timeout", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.in_valid  = 1'b0;
    bus.gray_in   = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_binario_out", {24'd0, bus.binario_out}, 32'd0);
    check("rst_ocupado", {31'd0, bus.ocupado}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Zero word and directed values
    bus.out_ready = 1'b1;
    send(8'h00, 8'h00);
    drain();
    send(8'hC0, 8'h80);
    drain();
    send(8'h80, 8'hFF);
    drain();
    send(8'h01, 8'h01);
    drain();

    // Result is held after the handoff
    repeat (5) @(posedge clk);
    #1;
    check("hold_after_handoff", {24'd0, bus.binario_out}, 32'h01);
    check("idle_out_valid", {31'd0, bus.out_valid}, 32'd0);

    // Backpressure in DONE with a competing input word
    bus.out_ready = 1'b0;
    send(to_gray(8'h3C), 8'h3C);
    for (int i = 0; i < TIMEOUT && !bus.out_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.gray_in  = WIDTH'($urandom_range(0, 255));
      @(negedge clk);
      check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_binario_out", {24'd0, bus.binario_out}, 32'h3C);
      check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    repeat (12) @(posedge clk);
    #1;
    check("bp_no_extra_word", {31'd0, bus.out_valid}, 32'd0);

    // Reset pulse at DECODE edge 4
    send(to_gray(8'h96), 8'h96);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    exp_busy = 1'b0;
    #1;
    check("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("abort_binario_out", {24'd0, bus.binario_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
    send(to_gray(8'h5B), 8'h5B);
    drain();

    // Exhaustive round trip, back-to-back with out_ready held high
    bb_mode   = 1'b1;
    last_rise = -1;
    for (int v = 0; v < 256; v++) send(to_gray(WIDTH'(v)), WIDTH'(v));
    drain();
    bb_mode = 1'b0;

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
